// File: rtl/fp_add_arbiter.sv
// rtl/fp_add_arbiter.sv - two-requester round-robin front end for a shared FP adder core
// A transaction runs IDLE -> ISSUE -> WAIT -> RESPOND. A missing core_done aborts it with status 15.
module fp_add_arbiter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clock_100kHz,
  input  logic        reset,
  input  logic        req_0,
  input  logic        req_1,
  input  logic [31:0] op_a_0,
  input  logic [31:0] op_b_0,
  input  logic [31:0] op_a_1,
  input  logic [31:0] op_b_1,
  output logic        done_0,
  output logic        done_1,
  output logic [31:0] result_0,
  output logic [31:0] result_1,
  output logic [3:0]  status_0,
  output logic [3:0]  status_1,
  output logic        core_start,
  output logic [31:0] core_op_a,
  output logic [31:0] core_op_b,
  input  logic        core_done,
  input  logic [31:0] core_result,
  input  logic [3:0]  core_status,
  output logic        busy,
  output logic        timeout_err,
  output logic [15:0] served_count
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_WAIT    = 2'd2;
  localparam logic [1:0] ST_RESPOND = 2'd3;

  // The counter starts at 0 on the first WAIT cycle, so the last allowed WAIT cycle sees TIMEOUT_CYCLES-1.
  localparam logic [7:0] WAIT_LIMIT    = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] STATUS_TIMEOUT = 4'hF;

  logic [1:0] state;
  logic       owner;
  logic       last_grant;
  logic [7:0] wait_count;
  logic       grant;

  // On a tie the requester that lost the previous grant wins; a lone request wins outright.
  assign grant = (req_0 && req_1) ? ~last_grant : req_1;
  assign busy  = (state != ST_IDLE);

  always_ff @(posedge clock_100kHz or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      owner        <= 1'b0;
      last_grant   <= 1'b1;
      wait_count   <= 8'd0;
      done_0       <= 1'b0;
      done_1       <= 1'b0;
      result_0     <= 32'd0;
      result_1     <= 32'd0;
      status_0     <= 4'd0;
      status_1     <= 4'd0;
      core_start   <= 1'b0;
      core_op_a    <= 32'd0;
      core_op_b    <= 32'd0;
      timeout_err  <= 1'b0;
      served_count <= 16'd0;
    end else begin
      core_start  <= 1'b0;
      done_0      <= 1'b0;
      done_1      <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_0 || req_1) begin
            owner      <= grant;
            last_grant <= grant;
            core_op_a  <= grant ? op_a_1 : op_a_0;
            core_op_b  <= grant ? op_b_1 : op_b_0;
            core_start <= 1'b1;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          wait_count <= 8'd0;
          state      <= ST_WAIT;
        end
        ST_WAIT: begin
          if (core_done) begin
            if (owner) begin
              result_1 <= core_result;
              status_1 <= core_status;
            end else begin
              result_0 <= core_result;
              status_0 <= core_status;
            end
            state <= ST_RESPOND;
          end else if (wait_count == WAIT_LIMIT) begin
            if (owner) begin
              result_1 <= 32'd0;
              status_1 <= STATUS_TIMEOUT;
            end else begin
              result_0 <= 32'd0;
              status_0 <= STATUS_TIMEOUT;
            end
            timeout_err <= 1'b1;
            state       <= ST_RESPOND;
          end else begin
            wait_count <= wait_count + 8'd1;
          end
        end
        ST_RESPOND: begin
          if (owner) begin
            done_1 <= 1'b1;
          end else begin
            done_0 <= 1'b1;
          end
          served_count <= served_count + 16'd1;
          state        <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_arbiter.sv
// tb/tb_fp_add_arbiter.sv - directed bench for fp_add_arbiter with a delay-programmable core model
`timescale 1ns/1ps
module tb_fp_add_arbiter;

  logic        clock_100kHz = 1'b0;
  logic        reset;
  logic        req_0, req_1;
  logic [31:0] op_a_0, op_b_0, op_a_1, op_b_1;
  logic        done_0, done_1;
  logic [31:0] result_0, result_1;
  logic [3:0]  status_0, status_1;
  logic        core_start;
  logic [31:0] core_op_a, core_op_b;
  logic        core_done = 1'b0;
  logic [31:0] core_result = 32'd0;
  logic [3:0]  core_status = 4'd0;
  logic        busy, timeout_err;
  logic [15:0] served_count;

  int errors = 0;
  int checks = 0;

  // Core model: answers core_delay cycles after the start pulse (0 means never answer).
  int          core_delay = 0;
  bit          use_fixed = 1'b1;
  logic [31:0] fixed_result = 32'd0;
  logic [3:0]  fixed_status = 4'd0;
  bit          core_pending = 1'b0;
  int          core_cnt = 0;

  fp_add_arbiter #(.TIMEOUT_CYCLES(64)) dut (
    .clock_100kHz(clock_100kHz), .reset(reset),
    .req_0(req_0), .req_1(req_1),
    .op_a_0(op_a_0), .op_b_0(op_b_0), .op_a_1(op_a_1), .op_b_1(op_b_1),
    .done_0(done_0), .done_1(done_1),
    .result_0(result_0), .result_1(result_1),
    .status_0(status_0), .status_1(status_1),
    .core_start(core_start), .core_op_a(core_op_a), .core_op_b(core_op_b),
    .core_done(core_done), .core_result(core_result), .core_status(core_status),
    .busy(busy), .timeout_err(timeout_err), .served_count(served_count)
  );

  always #5000 clock_100kHz = ~clock_100kHz;

  always @(negedge clock_100kHz) begin
    core_done = 1'b0;
    if (core_pending) begin
      core_cnt = core_cnt - 1;
      if (core_cnt == 0) begin
        core_done    = 1'b1;
        core_result  = use_fixed ? fixed_result : core_op_a + core_op_b;
        core_status  = fixed_status;
        core_pending = 1'b0;
      end
    end
    if (core_start && core_delay > 0) begin
      core_pending = 1'b1;
      core_cnt     = core_delay;
    end
  end

  task automatic do_reset();
    @(negedge clock_100kHz);
    reset = 1'b0;
    req_0 = 1'b0;
    req_1 = 1'b0;
    repeat (2) @(negedge clock_100kHz);
    reset = 1'b1;
  endtask

  // Steps through cycles first..last and records the first cycle each event is seen (-1 if never).
  task automatic run_until_done(input int first, input int last, output int d0, output int d1,
                                output int te, output int st);
    d0 = -1; d1 = -1; te = -1; st = -1;
    for (int c = first; c <= last; c++) begin
      @(negedge clock_100kHz);
      if (core_start && st < 0) st = c;
      if (timeout_err && te < 0) te = c;
      if (done_0 && d0 < 0) d0 = c;
      if (done_1 && d1 < 0) d1 = c;
      if (d0 >= 0 || d1 >= 0) break;
    end
  endtask

  task automatic test_basic();
    int d0, d1, te, st;
    do_reset();
    core_delay = 2; use_fixed = 1'b1; fixed_result = 32'h41000000; fixed_status = 4'd0;
    op_a_0 = 32'h40800000; op_b_0 = 32'h40800000;
    req_0 = 1'b1;
    run_until_done(1, 30, d0, d1, te, st);
    req_0 = 1'b0;
    checks++; if (st !== 1) begin errors++; $display("FAIL basic_start_cycle: got %0d expected 1", st); end
    checks++; if (d0 !== 5) begin errors++; $display("FAIL basic_done_cycle: got %0d expected 5", d0); end
    checks++; if (d1 !== -1 || te !== -1) begin errors++; $display("FAIL basic_spurious: done_1 %0d timeout %0d expected -1 -1", d1, te); end
    checks++; if (result_0 !== 32'h41000000) begin errors++; $display("FAIL basic_result: got %h expected 41000000", result_0); end
    checks++; if (status_0 !== 4'd0) begin errors++; $display("FAIL basic_status: got %0d expected 0", status_0); end
    checks++; if (served_count !== 16'd1) begin errors++; $display("FAIL basic_served: got %0d expected 1", served_count); end
    checks++; if (core_op_a !== 32'h40800000) begin errors++; $display("FAIL basic_core_op_a: got %h expected 40800000", core_op_a); end
    @(negedge clock_100kHz);
    checks++; if (done_0 !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_single_pulse: done_0 %b busy %b expected 0 0", done_0, busy); end
  endtask

  task automatic test_reset();
    @(negedge clock_100kHz);
    reset = 1'b0;
    #1;
    checks++; if (result_0 !== 32'd0 || status_0 !== 4'd0 || result_1 !== 32'd0 || status_1 !== 4'd0)
      begin errors++; $display("FAIL reset_results: got %h %h %h %h expected zeros", result_0, status_0, result_1, status_1); end
    checks++; if (served_count !== 16'd0) begin errors++; $display("FAIL reset_served: got %0d expected 0", served_count); end
    checks++; if (core_op_a !== 32'd0 || core_op_b !== 32'd0 || core_start !== 1'b0)
      begin errors++; $display("FAIL reset_core: got %h %h %b expected 0 0 0", core_op_a, core_op_b, core_start); end
    checks++; if (busy !== 1'b0 || timeout_err !== 1'b0 || done_0 !== 1'b0 || done_1 !== 1'b0)
      begin errors++; $display("FAIL reset_flags: got %b%b%b%b expected 0000", busy, timeout_err, done_0, done_1); end
    repeat (2) @(negedge clock_100kHz);
    reset = 1'b1;
  endtask

  task automatic test_round_robin();
    int order[4];
    int n = 0;
    int overlap = 0;
    int bad_res = 0;
    do_reset();
    core_delay = 1; use_fixed = 1'b0; fixed_status = 4'd0;
    op_a_0 = 32'h100; op_b_0 = 32'h1;
    op_a_1 = 32'h200; op_b_1 = 32'h2;
    req_0 = 1'b1; req_1 = 1'b1;
    for (int c = 1; c <= 60 && n < 4; c++) begin
      @(negedge clock_100kHz);
      if (done_0 && done_1) overlap++;
      if (done_0) begin order[n] = 0; n++; if (result_0 !== 32'h101) bad_res++; end
      else if (done_1) begin order[n] = 1; n++; if (result_1 !== 32'h202) bad_res++; end
    end
    req_0 = 1'b0; req_1 = 1'b0;
    checks++; if (n !== 4) begin errors++; $display("FAIL rr_count: got %0d expected 4", n); end
    checks++; if (n == 4 && (order[0] !== 0 || order[1] !== 1 || order[2] !== 0 || order[3] !== 1))
      begin errors++; $display("FAIL rr_order: got %0d%0d%0d%0d expected 0101", order[0], order[1], order[2], order[3]); end
    checks++; if (overlap !== 0) begin errors++; $display("FAIL rr_overlap: got %0d expected 0", overlap); end
    checks++; if (bad_res !== 0) begin errors++; $display("FAIL rr_results: got %0d bad expected 0", bad_res); end
    checks++; if (served_count !== 16'd4) begin errors++; $display("FAIL rr_served: got %0d expected 4", served_count); end
  endtask

  task automatic test_timeout();
    int d0, d1, te, st;
    core_delay = 0;
    op_a_1 = 32'h3F800000; op_b_1 = 32'h3F800000;
    req_1 = 1'b1;
    run_until_done(1, 100, d0, d1, te, st);
    req_1 = 1'b0;
    checks++; if (te !== 66) begin errors++; $display("FAIL timeout_err_cycle: got %0d expected 66", te); end
    checks++; if (d1 !== 67 || d0 !== -1) begin errors++; $display("FAIL timeout_done: done_1 %0d done_0 %0d expected 67 -1", d1, d0); end
    checks++; if (result_1 !== 32'd0 || status_1 !== 4'hF) begin errors++; $display("FAIL timeout_result: got %h %h expected 0 f", result_1, status_1); end
    checks++; if (result_0 !== 32'h101) begin errors++; $display("FAIL timeout_nonowner_hold: got %h expected 101", result_0); end
    checks++; if (served_count !== 16'd5) begin errors++; $display("FAIL timeout_served: got %0d expected 5", served_count); end
  endtask

  task automatic test_done_at_limit();
    int d0, d1, te, st;
    core_delay = 64; use_fixed = 1'b1; fixed_result = 32'h12345678; fixed_status = 4'd3;
    req_0 = 1'b1;
    run_until_done(1, 100, d0, d1, te, st);
    req_0 = 1'b0;
    checks++; if (d0 !== 67) begin errors++; $display("FAIL limit_done_cycle: got %0d expected 67", d0); end
    checks++; if (te !== -1) begin errors++; $display("FAIL limit_no_timeout: got %0d expected -1", te); end
    checks++; if (result_0 !== 32'h12345678 || status_0 !== 4'd3) begin errors++; $display("FAIL limit_result: got %h %h expected 12345678 3", result_0, status_0); end
    checks++; if (result_1 !== 32'd0 || status_1 !== 4'hF) begin errors++; $display("FAIL limit_nonowner_hold: got %h %h expected 0 f", result_1, status_1); end
  endtask

  task automatic test_reset_in_wait();
    int seen = 0;
    core_delay = 5; use_fixed = 1'b1; fixed_result = 32'hDEADBEEF; fixed_status = 4'd0;
    op_a_0 = 32'h11111111; op_b_0 = 32'h22222222;
    req_0 = 1'b1;
    repeat (3) @(negedge clock_100kHz);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstwait_busy_before: got %b expected 1", busy); end
    reset = 1'b0; req_0 = 1'b0;
    repeat (2) @(negedge clock_100kHz);
    reset = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock_100kHz);
      if (done_0 || done_1 || busy || timeout_err || core_start) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rstwait_activity: got %0d active cycles expected 0", seen); end
    checks++; if (result_0 !== 32'd0 || status_0 !== 4'd0 || served_count !== 16'd0 || core_op_a !== 32'd0)
      begin errors++; $display("FAIL rstwait_outputs: got %h %h %0d %h expected zeros", result_0, status_0, served_count, core_op_a); end
  endtask

  task automatic test_operand_hold();
    int d0, d1, te, st;
    core_delay = 3; use_fixed = 1'b1; fixed_result = 32'hCAFEF00D; fixed_status = 4'd1;
    op_a_0 = 32'h3F800000; op_b_0 = 32'h40000000;
    req_0 = 1'b1;
    @(negedge clock_100kHz);
    checks++; if (core_start !== 1'b1 || core_op_a !== 32'h3F800000) begin errors++; $display("FAIL hold_issue: got %b %h expected 1 3f800000", core_start, core_op_a); end
    @(negedge clock_100kHz);
    op_a_0 = 32'hFFFFFFFF; req_0 = 1'b0;
    run_until_done(3, 30, d0, d1, te, st);
    checks++; if (d0 !== 6) begin errors++; $display("FAIL hold_done_cycle: got %0d expected 6", d0); end
    checks++; if (result_0 !== 32'hCAFEF00D || status_0 !== 4'd1) begin errors++; $display("FAIL hold_result: got %h %h expected cafef00d 1", result_0, status_0); end
    @(negedge clock_100kHz);
    checks++; if (core_op_a !== 32'h3F800000 || core_op_b !== 32'h40000000) begin errors++; $display("FAIL hold_core_ops: got %h %h expected 3f800000 40000000", core_op_a, core_op_b); end
    checks++; if (busy !== 1'b0 || served_count !== 16'd1) begin errors++; $display("FAIL hold_idle: got busy %b served %0d expected 0 1", busy, served_count); end
  endtask

  initial begin
    reset = 1'b0;
    req_0 = 1'b0; req_1 = 1'b0;
    op_a_0 = 32'd0; op_b_0 = 32'd0; op_a_1 = 32'd0; op_b_1 = 32'd0;
    test_basic();
    test_reset();
    test_round_robin();
    test_timeout();
    test_done_at_limit();
    test_reset_in_wait();
    test_operand_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
